// File: rtl/prog_sequencer_pkg.sv
// Encodings shared by the program sequencer and its bench: opcodes, FSM states
// and the default no-op instruction presented to the datapath between issues.
package prog_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_OUT  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_WAIT_LOAD = 3'd3,
    S_ISSUE     = 3'd4,
    S_WAIT_OUT  = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  // MOV A,A: harmless when the datapath sees it without dp_issue
  localparam logic [7:0] NOP_INSTR = 8'h40;

  function automatic opcode_e opcode_of(input logic [7:0] instr);
    return opcode_e'(instr[7:6]);
  endfunction

endpackage

// File: rtl/prog_sequencer.sv
// Fetches instructions from a synchronous imem, gathers LOAD operands and OUT
// results over valid/ready handshakes, and issues one instruction at a time.
module prog_sequencer #(
  parameter int         PC_W      = 8,
  parameter logic [7:0] NOP_INSTR = prog_sequencer_pkg::NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            abort,
  input  logic [PC_W-1:0] prog_len,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  input  logic            ld_valid,
  input  logic [7:0]      ld_data,
  output logic            ld_ready,
  output logic [7:0]      dp_instr,
  output logic [7:0]      dp_load,
  output logic            dp_issue,
  input  logic [7:0]      dp_out,
  output logic            out_valid,
  output logic [7:0]      out_data,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);
  import prog_sequencer_pkg::*;

  state_e          state, state_nxt;
  logic [PC_W-1:0] pc, len, pc_inc;
  logic [7:0]      instr, load_r, out_r;
  logic            abort_run, last, adv, is_out;

  // abort only matters once a program is running; in IDLE it just masks start
  assign abort_run = abort && (state != S_IDLE);
  assign pc_inc    = pc + PC_W'(1);
  assign last      = (pc_inc == len);
  assign is_out    = (opcode_of(instr) == OP_OUT);
  assign adv       = !abort_run &&
                     ((state == S_ISSUE && !is_out) || (state == S_WAIT_OUT && out_ready));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_run) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (start && !abort) state_nxt = (prog_len == '0) ? S_DONE : S_FETCH;
        S_FETCH:     state_nxt = S_DECODE;
        S_DECODE:    state_nxt = (opcode_of(imem_data) == OP_LOAD) ? S_WAIT_LOAD : S_ISSUE;
        S_WAIT_LOAD: if (ld_valid) state_nxt = S_ISSUE;
        S_ISSUE:     state_nxt = is_out ? S_WAIT_OUT : (last ? S_DONE : S_FETCH);
        S_WAIT_OUT:  if (out_ready) state_nxt = last ? S_DONE : S_FETCH;
        S_DONE:      state_nxt = S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // Data registers; an abort in the same cycle drops whatever transfer completes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc     <= '0;
      len    <= '0;
      instr  <= NOP_INSTR;
      load_r <= '0;
      out_r  <= '0;
    end else begin
      if (state == S_IDLE && start && !abort && prog_len != '0) begin
        len <= prog_len;
        pc  <= '0;
      end
      if (state == S_DECODE && !abort)               instr  <= imem_data;
      if (state == S_WAIT_LOAD && ld_valid && !abort) load_r <= ld_data;
      // datapath has updated OUT on the falling edge inside ISSUE
      if (state == S_ISSUE && is_out && !abort)      out_r  <= dp_out;
      if (adv)                                       pc     <= pc_inc;
    end
  end

  always_comb begin
    dp_instr  = NOP_INSTR;
    dp_issue  = 1'b0;
    ld_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE:      busy      = 1'b0;
      S_WAIT_LOAD: ld_ready  = 1'b1;
      S_ISSUE: begin
        dp_instr = instr;
        dp_issue = 1'b1;
      end
      S_WAIT_OUT:  out_valid = 1'b1;
      S_DONE:      done      = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;
  assign dp_load   = load_r;
  assign out_data  = out_r;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboarded bench: programs are interpreted up front into expected issue and
// output queues; a negedge monitor drains them as the sequencer runs.
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  localparam int PC_W = 8;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] ld;
    bit         chk_ld;
  } iss_t;

  logic            CLK = 1'b0, RST = 1'b0, start = 1'b0, abort = 1'b0;
  logic [PC_W-1:0] prog_len = '0;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_data, dp_instr, dp_load, dp_out, out_data;
  logic [7:0]      ld_data = 8'h00;
  logic            ld_valid = 1'b0, out_ready = 1'b0;
  logic            ld_ready, dp_issue, out_valid, busy, done;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, iss_cnt = 0;
  int ld_delay = 0, or_delay = 0, ld_cnt = 0, or_cnt = 0;
  bit ld_auto = 1'b1, force_ld = 1'b0, rnd_dly = 1'b0;

  iss_t       exp_iss[$];
  logic [7:0] exp_out[$];
  logic [7:0] ld_vals[$];
  logic [7:0] mem [256];
  logic [7:0] m_r [8];
  logic [7:0] m_ld = 8'h00;

  prog_sequencer #(.PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .prog_len(prog_len),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .dp_instr(dp_instr), .dp_load(dp_load), .dp_issue(dp_issue), .dp_out(dp_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  always @(posedge CLK) imem_data <= mem[imem_addr];

  // Datapath: 8 registers, dst=[5:3], src=[2:0]; ADD is dst = src + A.
  logic       dp_rst;
  logic [7:0] dreg [8];
  assign dp_rst = ~RST;
  always @(negedge CLK or posedge dp_rst) begin
    if (dp_rst) begin
      for (int i = 0; i < 8; i++) dreg[i] <= 8'h00;
      dp_out <= 8'h00;
    end else if (dp_issue) begin
      case (dp_instr[7:6])
        2'b00:   dreg[dp_instr[5:3]] <= dp_load;
        2'b01:   dreg[dp_instr[5:3]] <= dreg[dp_instr[2:0]];
        2'b10:   dreg[dp_instr[5:3]] <= dreg[dp_instr[2:0]] + dreg[0];
        default: dp_out <= dreg[dp_instr[5:3]];
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Environment responders first (so the monitor sees what the next edge sees), then checks.
  initial begin : monitor
    iss_t       e;
    logic [7:0] eo, od_prev;
    bit         ov_prev;
    ov_prev = 1'b0;
    od_prev = 8'h00;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        ld_valid = 1'b0; out_ready = 1'b0; ld_cnt = 0; or_cnt = 0; ov_prev = 1'b0;
      end else begin
        if (ld_valid && !ld_ready) ld_valid = 1'b0;
        else if (ld_ready && !ld_valid && (force_ld || ld_auto)) begin
          if (force_ld || ld_cnt >= ld_delay) begin
            ld_valid = 1'b1;
            ld_data  = force_ld ? 8'hEE : (ld_vals.size() > 0 ? ld_vals[0] : 8'h00);
            ld_cnt   = 0;
            if (rnd_dly) ld_delay = $urandom_range(0, 3);
          end else ld_cnt++;
        end else if (!ld_ready) ld_cnt = 0;

        if (out_ready && !out_valid) out_ready = 1'b0;
        else if (out_valid && !out_ready) begin
          if (or_cnt >= or_delay) begin
            out_ready = 1'b1;
            or_cnt    = 0;
            if (rnd_dly) or_delay = $urandom_range(0, 3);
          end else or_cnt++;
        end else if (!out_valid) or_cnt = 0;

        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (dp_issue) begin
          iss_cnt++;
          if (exp_iss.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_issue: got dp_instr 0x%h, want no issue", dp_instr);
          end else begin
            e = exp_iss.pop_front();
            check("dp_instr", 32'(dp_instr), 32'(e.instr));
            if (e.chk_ld) check("dp_load", 32'(dp_load), 32'(e.ld));
          end
        end
        if (out_valid && ov_prev) check("out_hold", 32'(out_data), 32'(od_prev));
        if (out_valid && out_ready && !abort) begin
          if (exp_out.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_out: got out_data 0x%h, want no output", out_data);
          end else begin
            eo = exp_out.pop_front();
            check("out_data", 32'(out_data), 32'(eo));
          end
          ov_prev = 1'b0;
        end else ov_prev = out_valid;
        od_prev = out_data;
        if (ld_valid && ld_ready && !abort && ld_vals.size() > 0) void'(ld_vals.pop_front());
      end
    end
  end

  task automatic pulse_start(input int len, output int t0);
    @(posedge CLK); #1;
    prog_len = PC_W'(len);
    start    = 1'b1;
    t0       = cyc;
    @(posedge CLK); #1;
    start    = 1'b0;
  endtask

  // Interprets the program at instruction level to build expectations, then runs it.
  task automatic run_prog(input logic [7:0] prog[$], input logic [7:0] lds[$],
                          input int ld_d, input int or_d, input bit rnd, output int cycles);
    int t0, d0, i0, li;
    logic [7:0] ins, v;
    foreach (prog[i]) mem[i] = prog[i];
    ld_vals = lds; ld_delay = ld_d; or_delay = or_d; rnd_dly = rnd;
    li = 0;
    foreach (prog[i]) begin
      ins = prog[i];
      case (opcode_of(ins))
        OP_LOAD: begin
          v = lds[li]; li++;
          m_r[ins[5:3]] = v; m_ld = v;
          exp_iss.push_back('{instr: ins, ld: v, chk_ld: 1'b1});
        end
        OP_MOV: begin
          m_r[ins[5:3]] = m_r[ins[2:0]];
          exp_iss.push_back('{instr: ins, ld: 8'h00, chk_ld: 1'b0});
        end
        OP_ADD: begin
          m_r[ins[5:3]] = m_r[ins[2:0]] + m_r[0];
          exp_iss.push_back('{instr: ins, ld: 8'h00, chk_ld: 1'b0});
        end
        default: begin
          exp_out.push_back(m_r[ins[5:3]]);
          exp_iss.push_back('{instr: ins, ld: 8'h00, chk_ld: 1'b0});
        end
      endcase
    end
    d0 = done_cnt; i0 = iss_cnt;
    pulse_start(prog.size(), t0);
    while (done_cnt == d0 && cyc - t0 < 10000) @(posedge CLK);
    #1;
    check("done_pulses", done_cnt - d0, 1);
    cycles = done_cyc - t0;
    check("done_low", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("issue_count", iss_cnt - i0, prog.size());
    check("iss_drained", exp_iss.size(), 0);
    check("out_drained", exp_out.size(), 0);
    check("dp_load_final", 32'(dp_load), 32'(m_ld));
    exp_iss.delete(); exp_out.delete();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] p[$], l[$];
    logic [7:0] v;
    int cyc_n, t0, d0, i0, b0, k, n;
    for (int i = 0; i < 256; i++) mem[i] = NOP_INSTR;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_dp_instr", 32'(dp_instr), 32'(NOP_INSTR));
    check("rst_dp_issue", 32'(dp_issue), 32'd0);
    check("rst_dp_load", 32'(dp_load), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    // MOV B,A: one issue, done 4 cycles after start
    p.delete(); l.delete();
    p.push_back(8'h48);
    run_prog(p, l, 0, 0, 1'b0, cyc_n);
    check("mov_latency", cyc_n, 4);

    // LOAD A (3 stall cycles) then OUT A held 4 extra cycles
    p.delete(); l.delete();
    p.push_back(8'h00); p.push_back(8'hC0); l.push_back(8'h5A);
    run_prog(p, l, 3, 4, 1'b0, cyc_n);
    check("ldout_latency", cyc_n, 16);

    // A=3, B=4, C=B+A, OUT C -> 7
    p.delete(); l.delete();
    p.push_back(8'h00); p.push_back(8'h08); p.push_back(8'h91); p.push_back(8'hD0);
    l.push_back(8'h03); l.push_back(8'h04);
    run_prog(p, l, 0, 0, 1'b0, cyc_n);
    check("add_latency", cyc_n, 16);

    // empty program
    p.delete(); l.delete();
    b0 = busy_cnt;
    run_prog(p, l, 0, 0, 1'b0, cyc_n);
    check("len0_latency", cyc_n, 1);
    check("len0_busy_cycles", busy_cnt - b0, 1);

    // abort in WAIT_LOAD together with ld_valid
    mem[0] = 8'h00; mem[1] = 8'hC0;
    ld_auto = 1'b0;
    d0 = done_cnt; i0 = iss_cnt;
    pulse_start(2, t0);
    k = 0;
    while (!ld_ready && k < 20) begin
      @(posedge CLK); #1;
      k++;
    end
    check("abort_ld_ready_seen", 32'(ld_ready), 32'd1);
    force_ld = 1'b1; abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0; force_ld = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ld_ready", 32'(ld_ready), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_issue", iss_cnt - i0, 0);
    check("abort_dp_load", 32'(dp_load), 32'(m_ld));
    ld_auto = 1'b1;
    p.delete(); l.delete();
    p.push_back(8'h48);
    run_prog(p, l, 0, 0, 1'b0, cyc_n);
    check("post_abort_latency", cyc_n, 4);

    // random programs with random handshake delays
    for (int t = 0; t < 40; t++) begin
      p.delete(); l.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        v = 8'($urandom);
        p.push_back(v);
        if (v[7:6] == 2'b00) l.push_back(8'($urandom));
      end
      run_prog(p, l, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, cyc_n);
    end

    // largest program: pc runs to 2^PC_W-1
    p.delete(); l.delete();
    for (int i = 0; i < 255; i++) begin
      v = 8'($urandom);
      p.push_back(v);
      if (v[7:6] == 2'b00) l.push_back(8'($urandom));
    end
    run_prog(p, l, 0, 0, 1'b0, cyc_n);

    // reset asserted mid-WAIT_OUT acts without a clock edge
    mem[0] = 8'hC0;
    exp_iss.push_back('{instr: 8'hC0, ld: 8'h00, chk_ld: 1'b0});
    or_delay = 1000; rnd_dly = 1'b0;
    pulse_start(1, t0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge CLK); #1;
      k++;
    end
    check("rstmid_out_valid_seen", 32'(out_valid), 32'd1);
    @(posedge CLK); #3;
    RST = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_dp_instr", 32'(dp_instr), 32'(NOP_INSTR));
    check("rstmid_out_data", 32'(out_data), 32'd0);
    check("rstmid_imem_addr", 32'(imem_addr), 32'd0);
    exp_iss.delete(); exp_out.delete(); ld_vals.delete();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_ld = 8'h00; or_delay = 0;
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_no_restart", 32'(busy), 32'd0);
    p.delete(); l.delete();
    p.push_back(8'h00); p.push_back(8'h08); p.push_back(8'h91); p.push_back(8'hD0);
    l.push_back(8'h03); l.push_back(8'h04);
    run_prog(p, l, 1, 2, 1'b0, cyc_n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and imem_addr width.
REQ-002 SHALL have parameter NOP_INSTR, default 8'h40 (MOV A,A), instruction driven on dp_instr when not issuing.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports start  input  1  (begin program, pulse) and abort  input  1  (stop program).
REQ-006 SHALL have port prog_len  input  PC_W  instruction count, sampled on accepted start.
REQ-007 SHALL have ports imem_addr  output  PC_W  and imem_data  input  8  (sync memory, data valid one cycle after address).
REQ-008 SHALL have ports ld_valid  input  1, ld_data  input  8 and ld_ready  output  1 (load-operand handshake).
REQ-009 SHALL have ports dp_instr  output  8, dp_load  output  8 and dp_issue  output  1 (datapath INSTR/Load drive and issue qualifier).
REQ-010 SHALL have port dp_out  input  8  datapath OUT register value.
REQ-011 SHALL have ports out_valid  output  1, out_data  output  8 and out_ready  input  1 (result handshake).
REQ-012 SHALL have ports busy  output  1  (program running) and done  output  1  (one-cycle completion pulse).

Function
REQ-013 SHALL decode opcode = instr[7:6]: 00 LOAD, 01 MOV, 10 ADD, 11 OUT.
REQ-014 SHALL implement the states IDLE, FETCH, DECODE, WAIT_LOAD, ISSUE, WAIT_OUT and DONE.
REQ-015 SHALL, in IDLE on start with prog_len!=0, latch prog_len, clear pc, go to FETCH; with prog_len==0, go to DONE.
REQ-016 SHALL, in FETCH, drive imem_addr=pc and go to DECODE.
REQ-017 SHALL, in DECODE, latch imem_data as instr; go to WAIT_LOAD if opcode 00, otherwise to ISSUE.
REQ-018 SHALL, in WAIT_LOAD, hold ld_ready=1; on ld_valid&&ld_ready, latch ld_data into dp_load and go to ISSUE.
REQ-019 SHALL, in ISSUE, drive dp_instr=instr and dp_issue=1 for exactly one cycle, and hold dp_load stable throughout that cycle.
REQ-020 SHALL, at the ISSUE-exit edge for opcode 11, capture dp_out into out_data, set out_valid and go to WAIT_OUT; the datapath updates OUT on the falling edge within ISSUE.
REQ-021 SHALL, in WAIT_OUT, hold out_valid and out_data stable until out_ready, then clear out_valid and advance.
REQ-022 SHALL advance by incrementing pc; if pc+1==latched prog_len, go to DONE, else go to FETCH.
REQ-023 SHALL, in DONE, assert done for one cycle and return to IDLE.
REQ-024 SHALL complete MOV/ADD in 3 cycles (FETCH, DECODE, ISSUE); LOAD adds at least 1 WAIT_LOAD cycle; OUT adds at least 1 WAIT_OUT cycle.
REQ-025 SHALL drive dp_instr=NOP_INSTR and dp_issue=0 in every state except ISSUE.
REQ-026 SHALL assert busy in all states except IDLE.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL, on abort in any non-IDLE state, go to IDLE next cycle with no done pulse, clear out_valid and ld_ready, and never issue a partially fetched instruction; abort has priority over start.
REQ-029 SHALL, when abort and a handshake completion occur in the same cycle, give abort priority and drop the completed transfer.
REQ-030 SHALL count pc modulo 2^PC_W; prog_len==2^PC_W-1 is the largest program.

Reset
REQ-031 SHALL, while RST=0, force state IDLE, pc=0, imem_addr=0, dp_instr=NOP_INSTR, dp_load=0, dp_issue=0, ld_ready=0, out_valid=0, out_data=0, busy=0 and done=0, asynchronously.
REQ-032 SHALL restart only on a new start after reset deassertion; an in-flight program is lost.
REQ-033 SHALL require the integrating top to drive the datapath's active-high reset from the inverted RST.

Structure
REQ-034 SHALL place opcode constants, the state encoding and NOP_INSTR in a shared package used by the sequencer and its bench.
REQ-035 SHALL be a single module with no sub-module; the datapath is instantiated beside it, not inside it.

Verification
REQ-036 SHALL verify MOV: program {8'h48} (MOV B,A), prog_len=1 -> dp_issue high exactly 1 cycle, dp_instr=8'h48, done pulses 4 cycles after start.
REQ-037 SHALL verify LOAD and OUT: program {8'h00, 8'hC0}, ld_data=8'h5A after 3 stall cycles -> out_valid with out_data=8'h5A held until out_ready, then done.
REQ-038 SHALL verify ADD: load A=8'h03, B=8'h04, then ADD 8'h91 (C=B+A), then OUT C 8'hD0 -> out_data=8'h07.
REQ-039 SHALL verify prog_len=0 -> done next cycle, no dp_issue, busy high for 1 cycle.
REQ-040 SHALL verify abort in WAIT_LOAD with ld_valid high in the same cycle -> IDLE, no issue, no done; a subsequent start runs normally.
REQ-041 SHALL verify RST low mid-WAIT_OUT -> out_valid=0, busy=0 and dp_instr=8'h40 immediately, without waiting for a clock edge.
